gate_bank_pipe: RTL
===================

GATE_BANK_PIPE -- requirements
Module: gate_bank_pipe

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent gate channels (1..16).
REQ-002 SHALL have parameter W, default 8: operand width per channel in bits (1..32).
REQ-003 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port op, input, CH*3 bits: per-channel opcode; channel c uses bits [3c+2:3c].
REQ-009 SHALL have port a, input, CH*W bits: first operand per channel; channel c uses bits [W*c+W-1:W*c].
REQ-010 SHALL have port b, input, CH*W bits: second operand per channel, packed the same way as a.
REQ-011 SHALL have port fold, input, 1 bit: start a multi-beat accumulation.
REQ-012 SHALL have port last, input, 1 bit: final beat of an accumulation.
REQ-013 SHALL have port out_valid, output, 1 bit: y holds a result.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes y this cycle.
REQ-015 SHALL have port y, output, CH*W bits: per-channel result, packed the same way as a.
REQ-016 SHALL have port beat_cnt, output, CNT_W bits: count of accepted beats.

Function
REQ-017 SHALL decode op as: 0 AND, 1 OR, 2 XOR, 3 NOT x, 4 NAND, 5 NOR, 6 XNOR, 7 BUF x; all operations are bitwise over W bits; x is the first operand.
REQ-018 SHALL accept a beat exactly when in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-020 SHALL implement two states: IDLE and ACCUM.
REQ-021 In IDLE, on an accepted beat with fold=0, SHALL load y with op(a,b) per channel and set out_valid the next cycle; latency is 1.
REQ-022 In IDLE, on an accepted beat with fold=1 and last=0, SHALL load acc with op(a,b), enter ACCUM, and leave out_valid unchanged.
REQ-023 In IDLE, on an accepted beat with fold=1 and last=1, SHALL behave as REQ-021.
REQ-024 In ACCUM, on an accepted beat, SHALL use acc as the first operand and ignore a and fold.
REQ-025 In ACCUM, an accepted beat with last=0 SHALL update acc to op(acc,b).
REQ-026 In ACCUM, an accepted beat with last=1 SHALL load y with op(acc,b), set out_valid, clear acc, and return to IDLE.
REQ-027 SHALL sample op per beat, so channels may change opcode between beats.
REQ-028 SHALL clear out_valid when out_ready=1 and no result is being loaded in the same cycle.
REQ-029 When out_ready=1 and a result is loaded in the same cycle, SHALL keep out_valid at 1 and show the new y.
REQ-030 SHALL hold y stable while out_valid=1 and out_ready=0.
REQ-031 SHALL increment beat_cnt by 1 on every accepted beat and wrap from all-ones to 0.

Reset
REQ-032 On rst=1 at a clock edge, SHALL set state=IDLE, acc=0, y=0, out_valid=0, beat_cnt=0.
REQ-033 SHALL give rst priority over any simultaneous beat; a reset mid-ACCUM discards the accumulation with no output.
REQ-034 During and after reset, in_ready SHALL be 1, following REQ-019 with out_valid=0.

Verification (CH=4, W=8)
REQ-035 Bench SHALL cover reset: rst held 2 cycles -> y=0, out_valid=0, in_ready=1, beat_cnt=0.
REQ-036 Bench SHALL cover a single beat: ch0 XOR a=0xF0 b=0x3C, ch1 NOT a=0x0F, fold=0 -> next cycle out_valid=1, y ch0=0xCC, ch1=0xF0, beat_cnt=1.
REQ-037 Bench SHALL cover backpressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0 and y unchanged; out_ready=1 together with a new beat -> out_valid stays 1 and the new y appears.
REQ-038 Bench SHALL cover a 3-beat fold: AND, fold=1, a=0xFF b=0x0F; then b=0x07; then b=0x03 with last=1 -> out_valid=0 until after the last beat, then y ch0=0x03, beat_cnt +3.
REQ-039 Bench SHALL cover reset mid-ACCUM: rst after 2 fold beats -> state IDLE, no out_valid; a following fold=0 OR a=0x01 b=0x02 -> y ch0=0x03.
REQ-040 Bench SHALL cover counter wrap: preload by driving 0xFFFF accepted beats, then one more beat -> beat_cnt=0x0000.

Source files
------------

// File: rtl/gate_bank_pipe.sv
// Per-channel bitwise gate bank with single-slot output register.
// Multi-beat fold accumulates each channel through the selected gate.
module gate_bank_pipe #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*3-1:0]   op,
  input  logic [CH*W-1:0]   a,
  input  logic [CH*W-1:0]   b,
  input  logic              fold,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   y,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state, state_nx;
  logic [CH*W-1:0]   acc, acc_nx;
  logic [CH*W-1:0]   y_nx, res;
  logic              ov_nx;
  logic              accept;

  function automatic logic [W-1:0] gate(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] z
  );
    unique case (o)
      3'd0:    gate = x & z;
      3'd1:    gate = x | z;
      3'd2:    gate = x ^ z;
      3'd3:    gate = ~x;
      3'd4:    gate = ~(x & z);
      3'd5:    gate = ~(x | z);
      3'd6:    gate = ~(x ^ z);
      default: gate = x;
    endcase
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // While folding, the running accumulator replaces operand a.
  always_comb begin
    res = '0;
    for (int c = 0; c < CH; c++) begin
      res[c*W +: W] = gate(op[c*3 +: 3],
                           (state == ACCUM) ? acc[c*W +: W]
                                            : a[c*W +: W],
                           b[c*W +: W]);
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    y_nx     = y;
    ov_nx    = out_valid && !out_ready;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (fold && !last) begin
            acc_nx   = res;
            state_nx = ACCUM;
          end else begin
            y_nx  = res;
            ov_nx = 1'b1;
          end
        end
        ACCUM: begin
          if (last) begin
            y_nx     = res;
            ov_nx    = 1'b1;
            acc_nx   = '0;
            state_nx = IDLE;
          end else begin
            acc_nx = res;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      y         <= y_nx;
      out_valid <= ov_nx;
      if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule
